// File: rtl/parity_link_pkg.sv
// ---------------------------------------------------------------------------
// parity_link_pkg
// Definitions shared by the odd-parity serial link blocks: the generator, this
// receiver, and any later transmitter.
//   rx_state_t : receiver FSM states (IDLE, DATA, PARITY, STOP)
//   START_BIT  : line level that opens a frame
//   STOP_BIT   : line level that closes a well-formed frame
//   IDLE_LVL   : line level between frames
// ---------------------------------------------------------------------------
package parity_link_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;
    localparam logic IDLE_LVL  = 1'b0;

endpackage : parity_link_pkg

// File: rtl/odd_parity_frame_rx_if.sv
// ---------------------------------------------------------------------------
// odd_parity_frame_rx_if
// Groups the serial input and the recovered-frame outputs of the odd-parity
// frame receiver.
//   in       : serial line, one bit per clock (driven by the link side)
//   data_out : last received data word
//   valid    : one-cycle pulse per completed frame
//   par_err  : parity error of the last frame
//   frm_err  : stop-bit error of the last frame
//   good_cnt : saturating count of error-free frames
//   err_cnt  : saturating count of errored frames
// Modports: master = link side / consumer, slave = receiver.
// ---------------------------------------------------------------------------
interface odd_parity_frame_rx_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              in;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              par_err;
    logic              frm_err;
    logic [CNT_W-1:0]  good_cnt;
    logic [CNT_W-1:0]  err_cnt;

    modport master (
        output in,
        input  data_out,
        input  valid,
        input  par_err,
        input  frm_err,
        input  good_cnt,
        input  err_cnt
    );

    modport slave (
        input  in,
        output data_out,
        output valid,
        output par_err,
        output frm_err,
        output good_cnt,
        output err_cnt
    );
endinterface : odd_parity_frame_rx_if

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//   clk  : clock
//   arst : asynchronous active-high reset, clears the count
//   inc  : count enable, one increment per clock while high
//   cnt  : current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign cnt = cnt_reg;

endmodule : sat_counter

// File: rtl/odd_parity_frame_rx.sv
// ---------------------------------------------------------------------------
// odd_parity_frame_rx
// Receives frames on a one-bit-per-clock serial line:
//   start(1), DATA_W data bits LSB first, odd parity bit, stop(0).
// Publishes the recovered word with parity/framing flags and keeps saturating
// counts of good and errored frames.
//   clk  : clock, all state on rising edge
//   arst : asynchronous active-high reset
//   bus  : slave side of odd_parity_frame_rx_if (in, data_out, valid,
//          par_err, frm_err, good_cnt, err_cnt)
// ---------------------------------------------------------------------------
module odd_parity_frame_rx #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  arst,
    odd_parity_frame_rx_if.slave  bus
);
    import parity_link_pkg::*;

    localparam int                IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_W - 1);

    rx_state_t         state_reg;
    logic [DATA_W-1:0] shreg_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic              acc_reg;
    logic              perr_reg;

    logic [DATA_W-1:0] data_out_reg;
    logic              valid_reg;
    logic              par_err_reg;
    logic              frm_err_reg;

    // Counter enables are decoded from the STOP state and the live stop bit so
    // the counters step on the same edge that raises valid.
    logic              stop_cycle;
    logic              frame_bad;
    logic [1:0]        inc_vec;     // [0] good frame, [1] errored frame
    logic [CNT_W-1:0]  cnt_vec [2];

    assign stop_cycle = (state_reg == STOP);
    assign frame_bad  = perr_reg | (bus.in != STOP_BIT);
    assign inc_vec[0] = stop_cycle & ~frame_bad;
    assign inc_vec[1] = stop_cycle &  frame_bad;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_reg    <= IDLE;
            shreg_reg    <= '0;
            idx_reg      <= '0;
            acc_reg      <= 1'b0;
            perr_reg     <= 1'b0;
            data_out_reg <= '0;
            valid_reg    <= 1'b0;
            par_err_reg  <= 1'b0;
            frm_err_reg  <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.in == START_BIT) begin
                        state_reg <= DATA;
                        idx_reg   <= '0;
                        acc_reg   <= 1'b0;
                    end
                end
                DATA: begin
                    shreg_reg[idx_reg] <= bus.in;
                    acc_reg            <= acc_reg ^ bus.in;
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= PARITY;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                PARITY: begin
                    // Data ones plus parity bit must be odd; an even total is an error.
                    perr_reg  <= ~(acc_reg ^ bus.in);
                    state_reg <= STOP;
                end
                STOP: begin
                    // The stop sample is always consumed here, so a bad stop
                    // bit of 1 can never be mistaken for the next start bit.
                    data_out_reg <= shreg_reg;
                    par_err_reg  <= perr_reg;
                    frm_err_reg  <= (bus.in != STOP_BIT);
                    valid_reg    <= 1'b1;
                    state_reg    <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk  (clk),
                .arst (arst),
                .inc  (inc_vec[gi]),
                .cnt  (cnt_vec[gi])
            );
        end
    endgenerate

    assign bus.data_out = data_out_reg;
    assign bus.valid    = valid_reg;
    assign bus.par_err  = par_err_reg;
    assign bus.frm_err  = frm_err_reg;
    assign bus.good_cnt = cnt_vec[0];
    assign bus.err_cnt  = cnt_vec[1];

endmodule : odd_parity_frame_rx

// File: tb/tb_odd_parity_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_odd_parity_frame_rx
// Scoreboard bench for odd_parity_frame_rx. Two receivers: dut_a (CNT_W=8)
// for the frame scenarios and dut_s (CNT_W=2) for counter saturation.
// ---------------------------------------------------------------------------
module tb_odd_parity_frame_rx;
    import parity_link_pkg::*;

    logic clk = 1'b0;
    logic arst;
    logic line;
    logic sel;      // 0: stimulus goes to dut_a, 1: to dut_s
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    odd_parity_frame_rx_if #(.DATA_W(8), .CNT_W(8)) bus_a ();
    odd_parity_frame_rx_if #(.DATA_W(8), .CNT_W(2)) bus_s ();

    assign bus_a.in = sel ? IDLE_LVL : line;
    assign bus_s.in = sel ? line : IDLE_LVL;

    odd_parity_frame_rx #(.DATA_W(8), .CNT_W(8)) dut_a (
        .clk  (clk),
        .arst (arst),
        .bus  (bus_a)
    );

    odd_parity_frame_rx #(.DATA_W(8), .CNT_W(2)) dut_s (
        .clk  (clk),
        .arst (arst),
        .bus  (bus_s)
    );

    typedef struct packed {
        int         stamp;   // edge number at which valid rose
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic [7:0] good;
        logic [7:0] err;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   good_m     = 0;
    int   err_m      = 0;
    int   cnt_max    = 255;

    // Capture every cycle in which the selected receiver shows valid.
    always @(negedge clk) begin
        rec_t r;
        if (!sel && bus_a.valid === 1'b1) begin
            r.stamp = cyc;
            r.data  = bus_a.data_out;
            r.perr  = bus_a.par_err;
            r.ferr  = bus_a.frm_err;
            r.good  = bus_a.good_cnt;
            r.err   = bus_a.err_cnt;
            obs_q.push_back(r);
        end
        if (sel && bus_s.valid === 1'b1) begin
            r.stamp = cyc;
            r.data  = bus_s.data_out;
            r.perr  = bus_s.par_err;
            r.ferr  = bus_s.frm_err;
            r.good  = {6'b0, bus_s.good_cnt};
            r.err   = {6'b0, bus_s.err_cnt};
            obs_q.push_back(r);
        end
    end

    // Drive one full frame starting at the next falling edge; push the
    // expected result computed from the bit counts and the counter model.
    task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb);
        rec_t e;
        logic bad_par;
        @(negedge clk);
        line    = START_BIT;
        e.stamp = cyc + 1 + 10;      // start at edge k, valid visible after edge k+10
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            line = d[i];
        end
        @(negedge clk);
        line = pb;
        @(negedge clk);
        line = sb;
        bad_par = (($countones({d, pb}) % 2) == 0);
        if (!bad_par && !sb) good_m = (good_m >= cnt_max) ? good_m : good_m + 1;
        else                 err_m  = (err_m  >= cnt_max) ? err_m  : err_m + 1;
        e.data = d;
        e.perr = bad_par;
        e.ferr = sb;
        e.good = 8'(good_m);
        e.err  = 8'(err_m);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            line = IDLE_LVL;
        end
    endtask

    // Idle the line until n captures exist or the cycle budget runs out.
    task automatic wait_obs(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            line = IDLE_LVL;
            #1;
        end
        if (obs_q.size() >= n) ok = 1'b1;
    endtask

    task automatic test_reset;
        arst = 1'b1;
        line = IDLE_LVL;
        sel  = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if ({bus_a.data_out, bus_a.valid, bus_a.par_err, bus_a.frm_err, bus_a.good_cnt, bus_a.err_cnt} !== 27'd0) begin
            mismatched++;
            $display("FAIL reset_a: got data=%h valid=%b perr=%b ferr=%b good=%0d err=%0d, want all 0",
                     bus_a.data_out, bus_a.valid, bus_a.par_err, bus_a.frm_err, bus_a.good_cnt, bus_a.err_cnt);
        end
        compared++;
        if ({bus_s.data_out, bus_s.valid, bus_s.par_err, bus_s.frm_err, bus_s.good_cnt, bus_s.err_cnt} !== 15'd0) begin
            mismatched++;
            $display("FAIL reset_s: got data=%h valid=%b perr=%b ferr=%b good=%0d err=%0d, want all 0",
                     bus_s.data_out, bus_s.valid, bus_s.par_err, bus_s.frm_err, bus_s.good_cnt, bus_s.err_cnt);
        end
        arst = 1'b0;
        idle(5);
        compared++;
        if (obs_q.size() != 0 || bus_a.good_cnt !== 8'd0 || bus_a.err_cnt !== 8'd0) begin
            mismatched++;
            $display("FAIL reset_idle: got %0d valid pulses good=%0d err=%0d, want 0/0/0",
                     obs_q.size(), bus_a.good_cnt, bus_a.err_cnt);
        end
        obs_q.delete();
        $display("test_reset done");
    endtask

    task automatic test_good_frame;
        bit   ok;
        rec_t e, o;
        sel = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_obs(exp_q.size(), ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL good_frame_timeout: got %0d valid pulses, want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL good_frame: got edge=%0d data=%h perr=%b ferr=%b good=%0d err=%0d, want edge=%0d data=%h perr=%b ferr=%b good=%0d err=%0d",
                         o.stamp, o.data, o.perr, o.ferr, o.good, o.err, e.stamp, e.data, e.perr, e.ferr, e.good, e.err);
            end
            $display("good_frame: data=%h perr=%b ferr=%b good=%0d err=%0d", o.data, o.perr, o.ferr, o.good, o.err);
        end
        exp_q.delete();
        idle(12);
        compared++;
        if (obs_q.size() != 0) begin
            mismatched++;
            $display("FAIL good_frame_extra_valid: got %0d extra pulses, want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_parity_error;
        bit   ok;
        rec_t e, o;
        sel = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b0);
        wait_obs(exp_q.size(), ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL parity_err_timeout: got %0d valid pulses, want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL parity_err: got edge=%0d data=%h perr=%b ferr=%b good=%0d err=%0d, want edge=%0d data=%h perr=%b ferr=%b good=%0d err=%0d",
                         o.stamp, o.data, o.perr, o.ferr, o.good, o.err, e.stamp, e.data, e.perr, e.ferr, e.good, e.err);
            end
            $display("parity_err: data=%h perr=%b ferr=%b good=%0d err=%0d", o.data, o.perr, o.ferr, o.good, o.err);
        end
        exp_q.delete();
        idle(12);
        compared++;
        if (obs_q.size() != 0 || bus_a.par_err !== 1'b1) begin
            mismatched++;
            $display("FAIL parity_err_hold: got %0d extra pulses par_err=%b, want 0 and 1", obs_q.size(), bus_a.par_err);
        end
        obs_q.delete();
    endtask

    task automatic test_framing_error;
        bit   ok;
        rec_t e, o;
        sel = 1'b0;
        send_frame(8'h00, 1'b1, 1'b1);
        wait_obs(exp_q.size(), ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL framing_err_timeout: got %0d valid pulses, want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL framing_err: got edge=%0d data=%h perr=%b ferr=%b good=%0d err=%0d, want edge=%0d data=%h perr=%b ferr=%b good=%0d err=%0d",
                         o.stamp, o.data, o.perr, o.ferr, o.good, o.err, e.stamp, e.data, e.perr, e.ferr, e.good, e.err);
            end
            $display("framing_err: data=%h perr=%b ferr=%b good=%0d err=%0d", o.data, o.perr, o.ferr, o.good, o.err);
        end
        exp_q.delete();
        // A bad stop bit of 1 must not open a new frame: no pulse may follow.
        idle(14);
        compared++;
        if (obs_q.size() != 0) begin
            mismatched++;
            $display("FAIL framing_err_no_restart: got %0d extra pulses, want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_back_to_back;
        bit   ok;
        rec_t e, o;
        sel = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'h01, 1'b0, 1'b0);
        wait_obs(exp_q.size(), ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL back_to_back_timeout: got %0d valid pulses, want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL back_to_back: got edge=%0d data=%h perr=%b ferr=%b good=%0d err=%0d, want edge=%0d data=%h perr=%b ferr=%b good=%0d err=%0d",
                         o.stamp, o.data, o.perr, o.ferr, o.good, o.err, e.stamp, e.data, e.perr, e.ferr, e.good, e.err);
            end
            $display("back_to_back: edge=%0d data=%h good=%0d err=%0d", o.stamp, o.data, o.good, o.err);
        end
        exp_q.delete();
        idle(12);
        compared++;
        if (obs_q.size() != 0) begin
            mismatched++;
            $display("FAIL back_to_back_extra_valid: got %0d extra pulses, want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid_frame;
        bit         ok;
        rec_t       e, o;
        logic [7:0] partial;
        sel     = 1'b0;
        partial = 8'hFF;
        @(negedge clk);
        line = START_BIT;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            line = partial[i];
        end
        @(negedge clk);
        line = IDLE_LVL;
        arst = 1'b1;
        #1;
        compared++;
        if ({bus_a.data_out, bus_a.valid, bus_a.par_err, bus_a.frm_err, bus_a.good_cnt, bus_a.err_cnt} !== 27'd0) begin
            mismatched++;
            $display("FAIL reset_mid_clear: got data=%h valid=%b perr=%b ferr=%b good=%0d err=%0d, want all 0",
                     bus_a.data_out, bus_a.valid, bus_a.par_err, bus_a.frm_err, bus_a.good_cnt, bus_a.err_cnt);
        end
        @(negedge clk);
        arst   = 1'b0;
        good_m = 0;
        err_m  = 0;
        send_frame(8'h81, 1'b1, 1'b0);
        wait_obs(exp_q.size(), ok);
        compared++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            mismatched++;
            $display("FAIL reset_mid_count: got %0d valid pulses, want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL reset_mid: got edge=%0d data=%h perr=%b ferr=%b good=%0d err=%0d, want edge=%0d data=%h perr=%b ferr=%b good=%0d err=%0d",
                         o.stamp, o.data, o.perr, o.ferr, o.good, o.err, e.stamp, e.data, e.perr, e.ferr, e.good, e.err);
            end
            $display("reset_mid: data=%h good=%0d err=%0d", o.data, o.good, o.err);
        end
        exp_q.delete();
        obs_q.delete();
        idle(2);
    endtask

    task automatic test_saturation;
        bit         ok;
        rec_t       e, o;
        logic [7:0] words [5];
        logic [7:0] w;
        words   = '{8'h11, 8'h22, 8'h07, 8'hF0, 8'h5A};
        sel     = 1'b1;
        cnt_max = 3;
        good_m  = 0;
        err_m   = 0;
        idle(2);
        for (int f = 0; f < 5; f++) begin
            w = words[f];
            // Parity bit chosen so the total number of ones is odd.
            send_frame(w, ($countones(w) % 2) == 0, 1'b0);
            wait_obs(exp_q.size(), ok);
            compared++;
            if (!ok) begin
                mismatched++;
                $display("FAIL saturation_timeout: frame %0d got %0d pulses, want %0d", f, obs_q.size(), exp_q.size());
            end
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                compared++;
                if (o !== e) begin
                    mismatched++;
                    $display("FAIL saturation: got edge=%0d data=%h perr=%b ferr=%b good=%0d err=%0d, want edge=%0d data=%h perr=%b ferr=%b good=%0d err=%0d",
                             o.stamp, o.data, o.perr, o.ferr, o.good, o.err, e.stamp, e.data, e.perr, e.ferr, e.good, e.err);
                end
                $display("saturation: frame %0d data=%h good=%0d err=%0d", f, o.data, o.good, o.err);
            end
            exp_q.delete();
            obs_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        arst = 1'b1;
        line = IDLE_LVL;
        sel  = 1'b0;
        test_reset();
        test_good_frame();
        test_parity_error();
        test_framing_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_odd_parity_frame_rx
